button_conditioner: RTL and testbench

Front-end conditioner for the three raw push-buttons that drive time/date adjustment in the decade clock. It synchronises, debounces, and edge-detects each button. For increase and decrease it adds hold-to-auto-repeat. Its outputs are clean single-cycle pulses and debounced levels, consumed directly by the clock/calendar counter's set logic in the clk domain.

---
 rtl/button_pkg.sv | 16 +
 rtl/button_conditioner_if.sv | 24 ++
 rtl/btn_channel.sv | 127 ++++++++++++
 rtl/button_conditioner.sv | 67 ++++++
 tb/tb_button_conditioner.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/button_pkg.sv
// Shared types and 50 MHz timing defaults for the push-button conditioner.
package button_pkg;

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rpt_state_t;

  localparam int unsigned DefDebounceCycles    = 1_000_000;
  localparam int unsigned DefRepeatDelayCycles = 25_000_000;
  localparam int unsigned DefRepeatRateCycles  = 5_000_000;
  localparam int unsigned DefCntW              = 26;

  // Smallest counter width able to hold max_cycles.
  function automatic int unsigned cnt_width(input int unsigned max_cycles);
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Raw button inputs and conditioned pulse/level outputs of the button conditioner.
interface button_conditioner_if;

  logic butt_increase;
  logic butt_decrease;
  logic butt_change;
  logic inc_pulse;
  logic dec_pulse;
  logic change_pulse;
  logic inc_held;
  logic dec_held;
  logic change_held;

  modport master (
    output butt_increase, butt_decrease, butt_change,
    input  inc_pulse, dec_pulse, change_pulse, inc_held, dec_held, change_held
  );

  modport slave (
    input  butt_increase, butt_decrease, butt_change,
    output inc_pulse, dec_pulse, change_pulse, inc_held, dec_held, change_held
  );

endinterface

// File: rtl/btn_channel.sv
// One button: 2-flop synchroniser, debounce, press pulse and optional hold-to-repeat.
module btn_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES     = DefDebounceCycles,
  parameter int unsigned REPEAT_DELAY_CYCLES = DefRepeatDelayCycles,
  parameter int unsigned REPEAT_RATE_CYCLES  = DefRepeatRateCycles,
  parameter int unsigned CNT_W               = DefCntW,
  parameter bit          BTN_ACTIVE_LOW      = 1'b1,
  parameter bit          REPEAT_EN           = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic butt,
  output logic pulse,
  output logic held
);

  localparam logic [CNT_W-1:0] DbLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q, level;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             held_q, held_d, rise;
  logic             pulse_q, pulse_d;

  // Sync flops reset to the released raw value so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= BTN_ACTIVE_LOW;
      sync2_q  <= BTN_ACTIVE_LOW;
      db_cnt_q <= '0;
      held_q   <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= butt;
      sync2_q  <= sync1_q;
      db_cnt_q <= db_cnt_d;
      held_q   <= held_d;
      pulse_q  <= pulse_d;
    end
  end

  assign level = sync2_q ^ BTN_ACTIVE_LOW;

  always_comb begin
    db_cnt_d = '0;
    held_d   = held_q;
    if (level != held_q) begin
      if (db_cnt_q == DbLast) begin
        held_d = ~held_q;
      end else begin
        db_cnt_d = db_cnt_q + CNT_W'(1);
      end
    end
  end

  assign rise = held_d & ~held_q;

  if (REPEAT_EN) begin : g_rpt
    localparam logic [CNT_W-1:0] DelayLast = CNT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] RateLast  = CNT_W'(REPEAT_RATE_CYCLES - 1);

    rpt_state_t       state_q, state_d;
    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             fall;

    assign fall = held_q & ~held_d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= StIdle;
        rpt_cnt_q <= '0;
      end else begin
        state_q   <= state_d;
        rpt_cnt_q <= rpt_cnt_d;
      end
    end

    // Release wins over any pending repeat pulse in the same cycle.
    always_comb begin
      state_d   = state_q;
      rpt_cnt_d = rpt_cnt_q;
      pulse_d   = 1'b0;
      if (fall) begin
        state_d   = StIdle;
        rpt_cnt_d = '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (rise) begin
              state_d   = StDelay;
              rpt_cnt_d = '0;
              pulse_d   = 1'b1;
            end
          end
          StDelay: begin
            if (rpt_cnt_q == DelayLast) begin
              state_d   = StRepeat;
              rpt_cnt_d = '0;
              pulse_d   = 1'b1;
            end else begin
              rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
            end
          end
          StRepeat: begin
            if (rpt_cnt_q == RateLast) begin
              rpt_cnt_d = '0;
              pulse_d   = 1'b1;
            end else begin
              rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_d   = StIdle;
            rpt_cnt_d = '0;
          end
        endcase
      end
    end
  end else begin : g_no_rpt
    assign pulse_d = rise;
  end

  assign pulse = pulse_q;
  assign held  = held_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the increase/decrease/change buttons; inc and dec pulses mask each other.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES     = DefDebounceCycles,
  parameter int unsigned REPEAT_DELAY_CYCLES = DefRepeatDelayCycles,
  parameter int unsigned REPEAT_RATE_CYCLES  = DefRepeatRateCycles,
  parameter int unsigned CNT_W               = DefCntW,
  parameter bit          BTN_ACTIVE_LOW      = 1'b1
) (
  input logic                 clk,
  input logic                 rst_n,
  button_conditioner_if.slave bus
);

  logic inc_raw, dec_raw;

  btn_channel #(
    .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
    .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
    .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES),
    .CNT_W              (CNT_W),
    .BTN_ACTIVE_LOW     (BTN_ACTIVE_LOW),
    .REPEAT_EN          (1'b1)
  ) u_inc (
    .clk  (clk),
    .rst_n(rst_n),
    .butt (bus.butt_increase),
    .pulse(inc_raw),
    .held (bus.inc_held)
  );

  btn_channel #(
    .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
    .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
    .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES),
    .CNT_W              (CNT_W),
    .BTN_ACTIVE_LOW     (BTN_ACTIVE_LOW),
    .REPEAT_EN          (1'b1)
  ) u_dec (
    .clk  (clk),
    .rst_n(rst_n),
    .butt (bus.butt_decrease),
    .pulse(dec_raw),
    .held (bus.dec_held)
  );

  btn_channel #(
    .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
    .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
    .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES),
    .CNT_W              (CNT_W),
    .BTN_ACTIVE_LOW     (BTN_ACTIVE_LOW),
    .REPEAT_EN          (1'b0)
  ) u_change (
    .clk  (clk),
    .rst_n(rst_n),
    .butt (bus.butt_change),
    .pulse(bus.change_pulse),
    .held (bus.change_held)
  );

  // Masking only gates the outputs; both repeat FSMs keep their cadence.
  assign bus.inc_pulse = inc_raw & ~bus.dec_held;
  assign bus.dec_pulse = dec_raw & ~bus.inc_held;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: vector table, hand sequences and random stimulus vs a model.
module tb_button_conditioner;

  localparam int D      = 4;
  localparam int RD     = 10;
  localparam int RR     = 3;
  localparam int MaxCyc = 4096;

  typedef struct {
    int btn;
    int bounce;
    int press_len;
    int first_pulse;
    int n_pulses;
    int held_rise;
    int held_fall;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  button_conditioner_if bus ();

  button_conditioner #(
    .DEBOUNCE_CYCLES    (D),
    .REPEAT_DELAY_CYCLES(RD),
    .REPEAT_RATE_CYCLES (RR),
    .CNT_W              (8),
    .BTN_ACTIVE_LOW     (1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int valid_from = 0;
  int base;
  bit hist [3][MaxCyc];
  bit m_held [3];
  bit m_pulse [3];
  int m_press [3];

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %b want %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Held toggles at edge k when the last D synchronised samples (raw cycles k-D-2..k-3)
  // all disagree with it. Pulses: on the press edge, then RD after it, then every RR.
  task automatic model_edge(input bit in_rst);
    int k;
    int s;
    bit tog;
    k = cyc;
    for (int b = 0; b < 3; b++) begin
      m_pulse[b] = 1'b0;
      if (in_rst) begin
        m_held[b] = 1'b0;
      end else begin
        tog = (k - D - 2 >= valid_from);
        if (tog) begin
          for (int c = k - D - 2; c <= k - 3; c++) begin
            if (hist[b][c] == m_held[b]) tog = 1'b0;
          end
        end
        if (tog) begin
          m_held[b] = ~m_held[b];
          if (m_held[b]) begin
            m_press[b] = k;
            m_pulse[b] = 1'b1;
          end
        end else if (m_held[b] && b != 2) begin
          s = k - m_press[b];
          if (s >= RD && (s - RD) % RR == 0) m_pulse[b] = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input bit rst, input bit inc, input bit dec, input bit chg);
    rst_n             = rst;
    bus.butt_increase = ~inc;
    bus.butt_decrease = ~dec;
    bus.butt_change   = ~chg;
    if (cyc < MaxCyc) begin
      hist[0][cyc] = inc;
      hist[1][cyc] = dec;
      hist[2][cyc] = chg;
    end
    if (!rst) begin
      valid_from = cyc + 1;
      #1;
      check_bit("async_rst_outputs", bus.inc_pulse | bus.dec_pulse | bus.change_pulse |
                bus.inc_held | bus.dec_held | bus.change_held, 1'b0);
    end
    @(posedge clk);
    cyc++;
    #1;
    model_edge(!rst);
    check_bit("inc_held", bus.inc_held, m_held[0]);
    check_bit("dec_held", bus.dec_held, m_held[1]);
    check_bit("change_held", bus.change_held, m_held[2]);
    check_bit("inc_pulse", bus.inc_pulse, m_pulse[0] & ~m_held[1]);
    check_bit("dec_pulse", bus.dec_pulse, m_pulse[1] & ~m_held[0]);
    check_bit("change_pulse", bus.change_pulse, m_pulse[2]);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    vec_t vecs [6];
    int   first, n, rise, fall, r;
    bit   prev, p, pl, hl;
    int   exp_q [$];
    int   got_q [$];
    int   rem [3];
    bit   lv [3];

    rst_n             = 1'b0;
    bus.butt_increase = 1'b1;
    bus.butt_decrease = 1'b1;
    bus.butt_change   = 1'b1;

    // {btn, bounce, press_len, first_pulse, n_pulses, held_rise, held_fall}
    vecs[0] = '{0, 0, 30, 6, 8, 6, 36};   // clean press with repeats
    vecs[1] = '{1, 20, 10, 26, 1, 26, 36}; // bounce then press
    vecs[2] = '{2, 0, 3, -1, 0, -1, -1};  // glitch shorter than debounce
    vecs[3] = '{2, 0, 60, 6, 1, 6, 66};   // change has no repeat
    vecs[4] = '{0, 0, 4, 6, 1, 6, 10};    // press exactly debounce long
    vecs[5] = '{0, 0, 10, 6, 1, 6, 16};   // release lands on first repeat slot

    for (int i = 0; i < 6; i++) begin
      do_reset();
      base  = cyc;
      first = -1;
      n     = 0;
      rise  = -1;
      fall  = -1;
      prev  = 1'b0;
      for (int c = 0; c < 80; c++) begin
        if (c < vecs[i].bounce) p = ((c / 2) % 2 == 0);
        else                    p = (c < vecs[i].bounce + vecs[i].press_len);
        step(1'b1, p && vecs[i].btn == 0, p && vecs[i].btn == 1, p && vecs[i].btn == 2);
        r = cyc - base;
        case (vecs[i].btn)
          0:       begin pl = bus.inc_pulse;    hl = bus.inc_held;    end
          1:       begin pl = bus.dec_pulse;    hl = bus.dec_held;    end
          default: begin pl = bus.change_pulse; hl = bus.change_held; end
        endcase
        if (pl) begin
          n++;
          if (first < 0) first = r;
        end
        if (hl && !prev && rise < 0) rise = r;
        if (!hl && prev && fall < 0) fall = r;
        prev = hl;
      end
      check_int($sformatf("row%0d_first_pulse", i), first, vecs[i].first_pulse);
      check_int($sformatf("row%0d_pulse_count", i), n, vecs[i].n_pulses);
      check_int($sformatf("row%0d_held_rise", i), rise, vecs[i].held_rise);
      check_int($sformatf("row%0d_held_fall", i), fall, vecs[i].held_fall);
    end

    // Interlock: inc held 0..59, dec held 20..39.
    do_reset();
    base  = cyc;
    exp_q = '{6, 16, 19, 22, 25, 46, 49, 52, 55};
    got_q = {};
    n     = 0;
    rise  = -1;
    fall  = -1;
    prev  = 1'b0;
    for (int c = 0; c < 70; c++) begin
      step(1'b1, c < 60, c >= 20 && c < 40, 1'b0);
      r = cyc - base;
      if (bus.inc_pulse && r <= 55) got_q.push_back(r);
      if (bus.dec_pulse) n++;
      if (bus.dec_held && !prev && rise < 0) rise = r;
      if (!bus.dec_held && prev && fall < 0) fall = r;
      prev = bus.dec_held;
    end
    check_int("ilk_inc_count", got_q.size(), exp_q.size());
    for (int j = 0; j < exp_q.size(); j++) begin
      check_int($sformatf("ilk_inc_pulse%0d", j), (j < got_q.size()) ? got_q[j] : -1, exp_q[j]);
    end
    check_int("ilk_dec_pulses", n, 0);
    check_int("ilk_dec_held_rise", rise, 26);
    check_int("ilk_dec_held_fall", fall, 46);

    // Reset mid-hold: inc held throughout, rst_n low in cycles 12..14.
    do_reset();
    base  = cyc;
    exp_q = '{6, 21, 31, 34, 37, 40};
    got_q = {};
    for (int c = 0; c < 50; c++) begin
      step(!(c >= 12 && c <= 14), 1'b1, 1'b0, 1'b0);
      r = cyc - base;
      if (bus.inc_pulse && r <= 40) got_q.push_back(r);
    end
    check_int("rst_inc_count", got_q.size(), exp_q.size());
    for (int j = 0; j < exp_q.size(); j++) begin
      check_int($sformatf("rst_inc_pulse%0d", j), (j < got_q.size()) ? got_q[j] : -1, exp_q[j]);
    end

    // Random press/bounce patterns with occasional resets, checked by the model each edge.
    do_reset();
    for (int b = 0; b < 3; b++) begin
      rem[b] = 0;
      lv[b]  = 1'b0;
    end
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (rem[b] == 0) begin
          lv[b] = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 3) == 0) rem[b] = int'($urandom_range(1, 3));
          else                           rem[b] = int'($urandom_range(4, 40));
        end
        rem[b]--;
      end
      step($urandom_range(0, 599) != 0, lv[0], lv[1], lv[2]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
